// File: rtl/mem_stall_ctrl.sv
// Memory-stage stall controller: generates the pipeline advance enable and
// sequences read-miss block refills and write-through stores to main memory.
`timescale 1ns/1ps
module mem_stall_ctrl #(
  parameter int SIZE        = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [SIZE-1:0] addr,
  input  logic [SIZE-1:0] writeData,
  input  logic            tag_match,
  output logic            hit,
  output logic            mem_req,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [SIZE-1:0] mem_rdata,
  output logic            fill_we,
  output logic [SIZE-1:0] fill_addr,
  output logic [SIZE-1:0] fill_data,
  output logic            fill_valid_set,
  output logic [15:0]     miss_count
);

  // state  | meaning
  // IDLE   | evaluate MEM-stage request; read hits advance with no stall
  // WRITE  | write-through store to main memory
  // REFILL | fetch BLOCK_WORDS words of the missing block into the cache
  // DONE   | one advance cycle; requests ignored so a held store is not reissued

  localparam int CW  = $clog2(BLOCK_WORDS);
  localparam int OFS = CW + 2;
  localparam logic [SIZE-1:0] BASE_MASK = ~SIZE'((2 ** OFS) - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_REFILL, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SIZE-1:0] r_addr;
  logic [SIZE-1:0] r_wdata;
  logic            r_tag;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_miss_count;
  logic            w_last;
  logic [SIZE-1:0] w_refill_addr;

  assign w_last        = (r_cnt == CW'(BLOCK_WORDS - 1));
  assign w_refill_addr = r_addr + (SIZE'(r_cnt) << 2);
  assign miss_count    = r_miss_count;

  // r_addr holds the store address in WRITE and the block base in REFILL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_tag        <= 1'b0;
      r_cnt        <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (MemWrite) begin
            r_addr  <= addr;
            r_wdata <= writeData;
            r_tag   <= tag_match;
          end else if (MemRead && !tag_match) begin
            r_addr <= addr & BASE_MASK;
            r_cnt  <= '0;
            if (r_miss_count != 16'hFFFF)
              r_miss_count <= r_miss_count + 16'd1;
          end
        end
        S_REFILL: begin
          if (mem_ack && !w_last)
            r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    hit            = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    fill_we        = 1'b0;
    fill_addr      = '0;
    fill_data      = '0;
    fill_valid_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemWrite) begin
          w_next = S_WRITE;
        end else if (MemRead && !tag_match) begin
          w_next = S_REFILL;
        end else begin
          hit = 1'b1;
        end
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        fill_addr = r_addr;
        fill_data = r_wdata;
        if (mem_ack) begin
          fill_we = r_tag;
          w_next  = S_DONE;
        end
      end
      S_REFILL: begin
        mem_req   = 1'b1;
        mem_addr  = w_refill_addr;
        fill_addr = w_refill_addr;
        fill_data = mem_rdata;
        if (mem_ack) begin
          fill_we = 1'b1;
          if (w_last) begin
            fill_valid_set = 1'b1;
            w_next         = S_DONE;
          end
        end
      end
      S_DONE: begin
        hit    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (!rst_n)
      hit = 1'b0;
  end

endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Memory-stage stall controller for the pipelined MIPS core. It watches the MEM-stage load/store request and the cache's combinational tag lookup, and generates `hit`, the advance/hold enable for MEM_WB and the upstream pipeline registers. On a read miss it sequences a block refill from main memory into the cache. On a store it performs a write-through transaction. It sits between the MEM stage, the cache arrays and the main-memory port.

## Interface
- `SIZE`, 32, data and address width.
- `BLOCK_WORDS`, 4, words per cache block; must be a power of 2 and at least 2.
- `clk` in 1: clock; all state changes on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MemRead` in 1: MEM-stage load request; held stable by the pipeline while `hit`=0.
- `MemWrite` in 1: MEM-stage store request; held stable while `hit`=0.
- `addr` in SIZE: byte address of the access; word aligned.
- `writeData` in SIZE: store data.
- `tag_match` in 1: combinational cache lookup for `addr` (valid and tag equal).
- `hit` out 1: pipeline advance enable (1 = advance, 0 = stall).
- `mem_req` out 1: main-memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out SIZE: main-memory byte address.
- `mem_wdata` out SIZE: main-memory write data.
- `mem_ack` in 1: transfer completes at the posedge where `mem_req`=1 and `mem_ack`=1.
- `mem_rdata` in SIZE: read data, valid when `mem_ack`=1.
- `fill_we` out 1: cache data-array write strobe.
- `fill_addr` out SIZE: cache write byte address.
- `fill_data` out SIZE: cache write data.
- `fill_valid_set` out 1: set the valid bit and tag for `fill_addr`'s block.
- `miss_count` out 16: saturating count of read misses.

## Operation
- States: IDLE, WRITE, REFILL, DONE.
- **IDLE**
  - If `MemWrite`=1 (this takes priority over `MemRead`): latch `addr`, `writeData` and `tag_match`, then go to WRITE.
  - Else if `MemRead`=1 and `tag_match`=0: latch base = `addr` with its low log2(BLOCK_WORDS)+2 bits cleared, clear the word counter, increment `miss_count` (saturating at 0xFFFF), then go to REFILL.
  - Otherwise stay in IDLE.
- **WRITE**
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr` = latched address, `mem_wdata` = latched data.
  - On ack: go to DONE. If the latched `tag_match`=1, also pulse `fill_we` with the latched address and data (write-through update).
  - A store miss does not allocate.
- **REFILL**
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr` = base + 4·cnt.
  - On each ack: pulse `fill_we`, with `fill_addr` = current `mem_addr` and `fill_data` = `mem_rdata`. Then cnt++.
  - On the ack for cnt = BLOCK_WORDS−1: also pulse `fill_valid_set`, then go to DONE.
- **DONE**: one cycle, then go to IDLE unconditionally. All request inputs are ignored in DONE, so a held store is not reissued.
- `hit` is combinational:
  - 1 in DONE.
  - In IDLE, 1 unless `MemWrite`=1, or `MemRead`=1 with `tag_match`=0.
  - 0 in WRITE and REFILL.
  - 0 while `rst_n`=0.
- `mem_req`, `mem_we` and `mem_addr` are decoded from registered state only; they do not depend on the current-cycle inputs. `mem_addr` and `mem_wdata` are stable while `mem_req`=1.
- `mem_ack` is ignored whenever `mem_req`=0.
- Word counter width is log2(BLOCK_WORDS). It never wraps during a refill, because the state exits on the last word.
- `fill_we` and `fill_valid_set` are 1-cycle pulses, asserted in the same cycle as the ack. `fill_addr` and `fill_data` are don't-care when `fill_we`=0.

## Timing
- Reset (asynchronous, from any state including mid-refill or mid-write):
  - State goes to IDLE; counter = 0, `miss_count` = 0.
  - `mem_req`, `mem_we`, `fill_we`, `fill_valid_set`, `hit` = 0; `mem_addr`, `mem_wdata`, `fill_addr`, `fill_data` = 0.
  - Any partial refill leaves the valid bit unset.
- Read hit: zero stall; `hit`=1 in the same cycle.
- Read miss, zero-wait memory: `hit`=0 for 1 + BLOCK_WORDS cycles, then `hit`=1 for the DONE cycle. `mem_req` rises in the cycle after detection.
- Each memory wait cycle adds 1 stall cycle.
- Store, zero-wait memory: `hit`=0 for 2 cycles, then DONE.
- Back-to-back requests: after DONE, IDLE re-evaluates the next instruction's inputs in the following cycle.
- Simultaneous `MemRead` and `MemWrite`: treated as a store.

## Test plan
- **Read hit.** `MemRead`=1, `tag_match`=1, `addr`=0x40 → `hit`=1 immediately; `mem_req` stays 0; `miss_count` unchanged.
- **Read miss, zero-wait memory.** BLOCK_WORDS=4, `addr`=0x104, `mem_ack`=1 constantly → `mem_addr` steps 0x100, 0x104, 0x108, 0x10C; `fill_we` pulses 4×; `fill_valid_set` with 0x10C; `hit`=0 for 5 cycles, then 1 for 1 cycle; `miss_count`=1.
- **Read miss with waits.** `mem_ack` delayed 2 cycles per word → `mem_addr` held during each wait; `hit` low for 13 cycles; `fill_data` equals `mem_rdata` on each ack.
- **Stores.**
  - Store hit, `addr`=0x20, `writeData`=0xDEADBEEF, ack after 3 cycles → `mem_we`=1 throughout; a single `fill_we` pulse with 0x20/0xDEADBEEF.
  - Store miss → no `fill_we`; `MemWrite` held through DONE issues only one `mem_req` transaction.
- **Reset mid-refill.** Drop `rst_n` after 2 acks → all outputs are 0 asynchronously; `fill_valid_set` never pulses; after release, state is IDLE and `hit` follows the inputs.
- **miss_count saturation.** Preload near 0xFFFF via repeated misses (or force) → the counter stays at 0xFFFF after a further miss.
